// File: rtl/etapa_desplazador.sv
// etapa_desplazador: RV32I shift execute stage (SLL/SRL/SRA and immediate forms).
// The request is decoded and shifted combinationally, then written into a small
// in-order output FIFO. Left shifts reuse the right shifter by bit-reversing the
// operand on the way in and the result on the way out.

// fn_des_der: combinational 32-bit right shifter, logical or arithmetic.
module fn_des_der (
  output logic [31:0] Y,
  input  logic [31:0] a,
  input  logic [4:0]  b,
  input  logic        con_signo
);
  logic [5:0][31:0] etapa;
  logic             relleno;

  // Vacated bits are filled with the sign bit only for arithmetic shifts.
  assign relleno  = con_signo & a[31];
  assign etapa[0] = a;

  // Logarithmic barrel: stage i shifts by 2^i when bit i of the amount is set.
  for (genvar i = 0; i < 5; i++) begin : g_etapa
    localparam int D = 1 << i;
    assign etapa[i+1] = b[i] ? {{D{relleno}}, etapa[i][31:D]} : etapa[i];
  end

  assign Y = etapa[5];
endmodule

module etapa_desplazador #(
  parameter int PROF       = 2,
  parameter int ANCHO_CONT = 16
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           operando,
  input  logic [4:0]            cantidad,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic [4:0]            rd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           resultado,
  output logic [4:0]            rd_out,
  output logic                  ilegal,
  output logic [ANCHO_CONT-1:0] num_ops
);
  localparam int PW = $clog2(PROF);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ilegal;
  } entrada_t;

  // Decode / datapath
  logic        es_sll, es_sr, con_signo;
  logic [31:0] op_rev, a_fn, y_fn, y_rev, res_calc;
  entrada_t    nueva;

  // Bit reversal on both sides of the right shifter turns it into a left shifter.
  for (genvar i = 0; i < 32; i++) begin : g_rev
    assign op_rev[i] = operando[31-i];
    assign y_rev[i]  = y_fn[31-i];
  end

  // Decode funct3/funct7[5]; anything not a legal shift yields 0 and is flagged.
  always_comb begin
    es_sll    = (funct3 == 3'b001) && !funct7_5;
    es_sr     = (funct3 == 3'b101);
    con_signo = es_sr && funct7_5;
    a_fn      = es_sll ? op_rev : operando;
    res_calc  = 32'h0;
    if (es_sll)     res_calc = y_rev;
    else if (es_sr) res_calc = y_fn;
    nueva.res    = res_calc;
    nueva.rd     = rd_in;
    nueva.ilegal = !(es_sll || es_sr);
  end

  fn_des_der u_des (
    .Y         (y_fn),
    .a         (a_fn),
    .b         (cantidad),
    .con_signo (con_signo)
  );

  // FIFO state
  entrada_t              mem_q [PROF];
  entrada_t              mem_d [PROF];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ANCHO_CONT-1:0] num_ops_q, num_ops_d;
  logic                  push, pop;

  // in_ready comes from registered occupancy only, never from out_ready.
  assign in_ready  = (count_q < CW'(PROF));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head fields read straight from storage; they stay put until the head is popped.
  assign resultado = mem_q[rd_ptr_q].res;
  assign rd_out    = mem_q[rd_ptr_q].rd;
  assign ilegal    = mem_q[rd_ptr_q].ilegal;
  assign num_ops   = num_ops_q;

  // Next-state for storage, pointers, occupancy and the pop counter.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    num_ops_d = num_ops_q;
    if (push) begin
      mem_d[wr_ptr_q] = nueva;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      num_ops_d = num_ops_q + ANCHO_CONT'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards any queued entries.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < PROF; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      num_ops_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      num_ops_q <= num_ops_d;
    end
  end
endmodule

// File: tb/tb_etapa_desplazador.sv
// Bench for etapa_desplazador: a queue-based reference model checked every cycle,
// plus literal expectations for the documented shift cases.
module tb_etapa_desplazador;
  localparam int PROF = 2;
  localparam int AC   = 16;

  logic          clk = 1'b0;
  logic          nreset;
  logic          in_valid, in_ready;
  logic [31:0]   operando;
  logic [4:0]    cantidad;
  logic [2:0]    funct3;
  logic          funct7_5;
  logic [4:0]    rd_in;
  logic          out_valid, out_ready;
  logic [31:0]   resultado;
  logic [4:0]    rd_out;
  logic          ilegal;
  logic [AC-1:0] num_ops;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        il;
  } ent_t;

  ent_t          mq[$];
  logic [AC-1:0] m_ops = '0;

  etapa_desplazador #(.PROF(PROF), .ANCHO_CONT(AC)) dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .operando(operando), .cantidad(cantidad), .funct3(funct3), .funct7_5(funct7_5),
    .rd_in(rd_in), .out_valid(out_valid), .out_ready(out_ready),
    .resultado(resultado), .rd_out(rd_out), .ilegal(ilegal), .num_ops(num_ops)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Architectural meaning of a shift request.
  function automatic ent_t ref_op(input logic [31:0] op, input logic [4:0] sh,
                                  input logic [2:0] f3, input logic f7, input logic [4:0] rd);
    ent_t e;
    e.rd = rd;
    e.il = 1'b0;
    if (f3 == 3'b001 && !f7)     e.res = op << sh;
    else if (f3 == 3'b101 && !f7) e.res = op >> sh;
    else if (f3 == 3'b101 && f7)  e.res = $unsigned($signed(op) >>> sh);
    else begin
      e.res = 32'h0;
      e.il  = 1'b1;
    end
    return e;
  endfunction

  // Reference model: in-order queue of depth PROF.
  always @(posedge clk) begin
    if (!nreset) begin
      mq.delete();
      m_ops = '0;
    end else begin
      bit acc, pp;
      acc = in_valid && (mq.size() < PROF);
      pp  = (mq.size() > 0) && out_ready;
      if (pp) begin
        void'(mq.pop_front());
        m_ops = m_ops + 1'b1;
      end
      if (acc) mq.push_back(ref_op(operando, cantidad, funct3, funct7_5, rd_in));
    end
  end

  always @(negedge nreset) begin
    mq.delete();
    m_ops = '0;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
    chk("in_ready", {31'b0, in_ready}, {31'b0, mq.size() < PROF});
    chk("num_ops", {16'b0, num_ops}, {16'b0, m_ops});
    if (mq.size() != 0) begin
      chk("head_res", resultado, mq[0].res);
      chk("head_rd", {27'b0, rd_out}, {27'b0, mq[0].rd});
      chk("head_il", {31'b0, ilegal}, {31'b0, mq[0].il});
    end
  end

  task automatic drive(input logic [31:0] op, input logic [4:0] sh,
                       input logic [2:0] f3, input logic f7, input logic [4:0] rd);
    in_valid = 1'b1; operando = op; cantidad = sh; funct3 = f3; funct7_5 = f7; rd_in = rd;
  endtask

  // Offer one request and return #2 after the edge that accepted it.
  task automatic send(input logic [31:0] op, input logic [4:0] sh,
                      input logic [2:0] f3, input logic f7, input logic [4:0] rd);
    int n = 0;
    @(posedge clk); #2;
    drive(op, sh, f3, f7, rd);
    while (!in_ready && n < 50) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=in_ready_low expected=accept");
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [AC-1:0] n0;
    nreset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    operando = '0; cantidad = '0; funct3 = '0; funct7_5 = 1'b0; rd_in = '0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_resultado", resultado, 32'h0);
    chk("rst_rd_out", {27'b0, rd_out}, 32'd0);
    chk("rst_ilegal", {31'b0, ilegal}, 32'd0);
    chk("rst_num_ops", {16'b0, num_ops}, 32'd0);
    @(posedge clk); #2 nreset = 1'b1;

    // Documented cases, checked one cycle after accept.
    send(32'h80000000, 5'd4, 3'b101, 1'b0, 5'd1);
    chk("srl_res", resultado, 32'h08000000);
    chk("srl_rd", {27'b0, rd_out}, 32'd1);
    send(32'h80000000, 5'd4, 3'b101, 1'b1, 5'd2);
    chk("sra_res", resultado, 32'hF8000000);
    send(32'h00000001, 5'd31, 3'b001, 1'b0, 5'd3);
    chk("sll31_res", resultado, 32'h80000000);
    send(32'h0000F00F, 5'd8, 3'b001, 1'b0, 5'd4);
    chk("sll8_res", resultado, 32'h00F00F00);
    send(32'h12345678, 5'd0, 3'b001, 1'b0, 5'd5);
    chk("sll0_res", resultado, 32'h12345678);
    send(32'h00000000 | 32'h0000ABCD, 5'd3, 3'b000, 1'b0, 5'd7);
    chk("ilg_flag", {31'b0, ilegal}, 32'd1);
    chk("ilg_res", resultado, 32'h0);
    chk("ilg_rd", {27'b0, rd_out}, 32'd7);

    // SRA sweep; model covers every amount, last one pinned literally.
    for (int s = 0; s < 32; s++) send(32'h80000000, 5'(s), 3'b101, 1'b1, 5'(s));
    chk("sra31_res", resultado, 32'hFFFFFFFF);

    // Backpressure: three offers, only PROF accepted.
    @(posedge clk); #2;
    out_ready = 1'b0;
    drive(32'h000000F0, 5'd4, 3'b101, 1'b0, 5'd10);
    @(posedge clk); #2;
    drive(32'h000000F0, 5'd1, 3'b001, 1'b0, 5'd11);
    @(posedge clk); #2;
    chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    drive(32'hF0000000, 5'd4, 3'b101, 1'b1, 5'd12);
    repeat (3) @(posedge clk);
    #2;
    chk("bp_still_full", {31'b0, in_ready}, 32'd0);
    chk("bp_head_rd", {27'b0, rd_out}, 32'd10);
    chk("bp_head_res", resultado, 32'h0000000F);
    n0 = num_ops;
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("drain1_rd", {27'b0, rd_out}, 32'd11);
    chk("drain1_ops", {16'b0, num_ops}, {16'b0, n0 + 16'd1});
    @(posedge clk); #2;
    in_valid = 1'b0;
    chk("drain2_rd", {27'b0, rd_out}, 32'd12);
    chk("drain2_res", resultado, 32'hFF000000);
    chk("drain2_ops", {16'b0, num_ops}, {16'b0, n0 + 16'd2});
    @(posedge clk); #2;

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      logic [2:0] f3;
      case ($urandom_range(0, 3))
        0:       f3 = 3'b001;
        1, 2:    f3 = 3'b101;
        default: f3 = 3'($urandom);
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      operando  = $urandom;
      cantidad  = 5'($urandom);
      funct3    = f3;
      funct7_5  = 1'($urandom);
      rd_in     = 5'($urandom);
      @(posedge clk); #2;
    end

    // Reset with two entries queued.
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    send(32'h0000000F, 5'd1, 3'b001, 1'b0, 5'd20);
    send(32'h0000000F, 5'd2, 3'b001, 1'b0, 5'd21);
    chk("pre_rst_full", {31'b0, in_ready}, 32'd0);
    #1 nreset = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_num_ops", {16'b0, num_ops}, 32'd0);
    @(posedge clk); #2 nreset = 1'b1;
    @(posedge clk); #2;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    send(32'h00000003, 5'd1, 3'b001, 1'b0, 5'd9);
    chk("post_rst_res", resultado, 32'h00000006);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
